// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between core requesters, the arbiter and unified memory.
// slave: arbiter view; master: environment view (core + memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ack;
  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ack;
  logic                  m_req;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_ack;
  logic                  err;
  logic                  err_src;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  m_rdata, m_ack,
    output if_rdata, if_ack,
    output d_rdata, d_ack,
    output m_req, m_we, m_be, m_addr, m_wdata,
    output err, err_src
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output m_rdata, m_ack,
    input  if_rdata, if_ack,
    input  d_rdata, d_ack,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    input  err, err_src
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one memory port with streak limit and watchdog.
// Ports: clk, rst (async active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_DSTRK = 4,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SK_W = $clog2(MAX_DSTRK + 1);

  typedef enum logic [1:0] {
    IDLE, GNT_IF, GNT_D, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SK_W-1:0]   streak_q, streak_d;
  logic [WD_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              err_src_q, err_src_d;
  logic              strk_ok, pick_d, is_d;

  // Data may take the port unless fetch has waited through a full streak.
  assign strk_ok = streak_q < SK_W'(MAX_DSTRK);
  assign pick_d  = bus.d_req & (~bus.if_req | strk_ok);
  assign is_d    = (state_q == GNT_D);

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    wdog_d     = wdog_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_src_d  = err_src_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    wdog_inc   = wdog_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d   = GNT_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_we ? bus.d_be : '1;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          wdog_d    = '0;
          if (bus.if_req && strk_ok)
            streak_d = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_d   = GNT_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = bus.if_addr;
          wdog_d    = '0;
          streak_d  = '0;
        end
      end
      GNT_IF, GNT_D: begin
        // A completing ack wins over a watchdog expiring the same cycle.
        if (bus.m_ack && m_req_q) begin
          state_d = DONE;
          m_req_d = 1'b0;
          if (is_d) begin
            d_rdata_d = bus.m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.m_rdata;
            if_ack_d   = 1'b1;
          end
        end else if (wdog_inc == WD_W'(TIMEOUT)) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          err_d     = 1'b1;
          err_src_d = is_d;
          if (is_d) begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end
        end else begin
          wdog_d = wdog_inc;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      wdog_q     <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      err_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      wdog_q     <= wdog_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      if_ack_q   <= if_ack_d;
      d_rdata_q  <= d_rdata_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      err_src_q  <= err_src_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.err      = err_q;
  assign bus.err_src  = err_src_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory.
// Memory acks in the ack_cyc-th cycle of m_req (0 = never acks).
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTRK(4), .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp;
  int          n_bad;
  int          ack_cyc;
  int          cnt;
  logic [31:0] rdata_src;
  logic [31:0] gnt_q[$];
  logic        req_prev;

  always @(negedge clk) begin
    bus.m_ack = 1'b0;
    if (!rst || !bus.m_req) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == ack_cyc) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = rdata_src;
      end
    end
    if (rst && bus.m_req && !req_prev)
      gnt_q.push_back(bus.m_addr);
    req_prev = bus.m_req;
  end

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_m_req: got %b want 0", bus.m_req);
    end
    n_cmp++;
    if ({bus.if_ack, bus.d_ack, bus.err, bus.err_src} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {bus.if_ack, bus.d_ack, bus.err, bus.err_src});
    end
    n_cmp++;
    if ({bus.m_we, bus.m_be, bus.m_addr} !== 37'b0) begin
      n_bad++;
      $display("FAIL rst_m_bus: got %h want 0",
               {bus.m_we, bus.m_be, bus.m_addr});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    ack_cyc     = 2;
    rdata_src   = 32'h0050_0093;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_req, bus.m_we, bus.m_be} !== 6'b101111) begin
      n_bad++;
      $display("FAIL fetch_m_ctl: got %b want 101111",
               {bus.m_req, bus.m_we, bus.m_be});
    end
    n_cmp++;
    if (bus.m_addr !== 32'h100) begin
      n_bad++; $display("FAIL fetch_m_addr: got %h want 100", bus.m_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b0) begin
      n_bad++; $display("FAIL fetch_early_ack: got %b want 0", bus.if_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h0050_0093) begin
      n_bad++;
      $display("FAIL fetch_ack: got %b/%h want 1/00500093",
               bus.if_ack, bus.if_rdata);
    end
    n_cmp++;
    if (bus.m_req !== 1'b0) begin
      n_bad++; $display("FAIL fetch_m_req_drop: got %b want 0", bus.m_req);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b0) begin
      n_bad++; $display("FAIL fetch_ack_pulse: got %b want 0", bus.if_ack);
    end
  endtask

  task automatic test_back_to_back;
    ack_cyc     = 2;
    rdata_src   = 32'h1111_2222;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b1111;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_req, bus.m_we} !== 2'b11 || bus.m_addr !== 32'h2000) begin
      n_bad++;
      $display("FAIL b2b_data_first: got %b/%h want 11/2000",
               {bus.m_req, bus.m_we}, bus.m_addr);
    end
    n_cmp++;
    if (bus.m_wdata !== 32'hDEAD_BEEF || bus.m_be !== 4'hF) begin
      n_bad++;
      $display("FAIL b2b_wdata: got %h/%h want DEADBEEF/F",
               bus.m_wdata, bus.m_be);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.d_ack, bus.if_ack} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_d_ack: got %b want 10", {bus.d_ack, bus.if_ack});
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.m_req, bus.m_we} !== 2'b10 || bus.m_addr !== 32'h104) begin
      n_bad++;
      $display("FAIL b2b_fetch_next: got %b/%h want 10/104",
               {bus.m_req, bus.m_we}, bus.m_addr);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL b2b_if_ack: got %b/%h want 1/11112222",
               bus.if_ack, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_streak;
    logic [31:0] exp [10];
    exp = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h300,
            32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h300};
    gnt_q.delete();
    ack_cyc     = 2;
    rdata_src   = 32'h1357_9BDF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'b0011;
    bus.d_addr  = 32'h4000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (bus.m_be !== 4'hF || bus.m_we !== 1'b0) begin
          n_bad++;
          $display("FAIL streak_load_be: got %h/%b want F/0",
                   bus.m_be, bus.m_we);
        end
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (gnt_q.size() !== 10) begin
      n_bad++; $display("FAIL streak_count: got %0d want 10", gnt_q.size());
    end
    for (int i = 0; i < 10 && i < gnt_q.size(); i++) begin
      n_cmp++;
      if (gnt_q[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL streak_gnt%0d: got %h want %h", i, gnt_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int hi;
    hi          = 0;
    ack_cyc     = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'hF;
    bus.d_addr  = 32'h5000;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.m_req) hi++;
      if (bus.err) break;
    end
    n_cmp++;
    if ({bus.err, bus.err_src, bus.d_ack} !== 3'b111) begin
      n_bad++;
      $display("FAIL tmo_err: got %b want 111",
               {bus.err, bus.err_src, bus.d_ack});
    end
    n_cmp++;
    if (bus.d_rdata !== 32'h0 || bus.m_req !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_rdata: got %h/%b want 0/0", bus.d_rdata, bus.m_req);
    end
    n_cmp++;
    if (hi !== 255) begin
      n_bad++; $display("FAIL tmo_len: got %0d want 255", hi);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.err, bus.err_src, bus.d_ack} !== 3'b010) begin
      n_bad++;
      $display("FAIL tmo_after: got %b want 010",
               {bus.err, bus.err_src, bus.d_ack});
    end
    ack_cyc     = 2;
    rdata_src   = 32'h0BAD_F00D;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h800;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h0BAD_F00D
        || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_recover: got %b/%h/%b want 1/0badf00d/0",
               bus.if_ack, bus.if_rdata, bus.err);
    end
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    ack_cyc     = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    @(negedge clk);
    n_cmp++;
    if (bus.m_req !== 1'b1) begin
      n_bad++; $display("FAIL rmid_pre: got %b want 1", bus.m_req);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0 || bus.m_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_async: got %b/%h want 0/0", bus.m_req, bus.m_addr);
    end
    n_cmp++;
    if (bus.err_src !== 1'b0 || bus.if_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_clr: got %b/%h want 0/0",
               bus.err_src, bus.if_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack, bus.err, bus.m_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_quiet: got %b want 000",
               {bus.if_ack, bus.err, bus.m_req});
    end
    ack_cyc   = 2;
    rdata_src = 32'h00A0_0113;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h00A0_0113) begin
      n_bad++;
      $display("FAIL rmid_fresh: got %b/%h want 1/00a00113",
               bus.if_ack, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exact_timeout;
    int n;
    n          = 0;
    ack_cyc    = 255;
    rdata_src  = 32'hCAFE_F00D;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h7000;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      n = c;
      if (bus.d_ack || bus.err) break;
    end
    n_cmp++;
    if ({bus.d_ack, bus.err} !== 2'b10) begin
      n_bad++;
      $display("FAIL exact_ack: got %b want 10", {bus.d_ack, bus.err});
    end
    n_cmp++;
    if (bus.d_rdata !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL exact_rdata: got %h want cafef00d", bus.d_rdata);
    end
    n_cmp++;
    if (n !== 256) begin
      n_bad++; $display("FAIL exact_cycle: got %0d want 256", n);
    end
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    ack_cyc     = 2;
    rdata_src   = '0;
    req_prev    = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;
    test_reset;
    test_fetch;
    test_back_to_back;
    test_streak;
    test_timeout;
    test_reset_mid;
    test_exact_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
